// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arb_pkg
// Description : Shared types and helpers for the round-robin arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package arb_pkg;

  localparam int ARB_MAX_REQ = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    LOCKED = 2'd2
  } arb_state_e;

  // Index width that never collapses to zero bits for tiny requester counts.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational rotate-priority picker (first set bit at or
//               after i_ptr, wrapping).
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
  import arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = clog2_min1(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  output logic               o_found,
  output logic [ID_W-1:0]    o_winner,
  output logic [NUM_REQ-1:0] o_onehot
);

  localparam logic [ID_W:0] C_NUM_REQ = (ID_W+1)'(NUM_REQ);

  logic [2*NUM_REQ-1:0] w_dbl;
  logic [NUM_REQ-1:0]   w_rot;
  logic [ID_W-1:0]      w_off;
  logic [ID_W:0]        w_sum;
  logic [ID_W-1:0]      w_winner;
  logic [NUM_REQ-1:0]   w_onehot;

  // Doubling the vector lets a plain right shift act as a rotate by i_ptr.
  assign w_dbl = {i_req, i_req} >> i_ptr;
  assign w_rot = w_dbl[NUM_REQ-1:0];

  always_comb begin
    w_off = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_off = ID_W'(k);
      end
    end
  end

  assign w_sum = {1'b0, i_ptr} + {1'b0, w_off};

  always_comb begin
    w_winner = '0;
    w_onehot = '0;
    if (w_sum >= C_NUM_REQ) begin
      w_winner = ID_W'(w_sum - C_NUM_REQ);
    end else begin
      w_winner = w_sum[ID_W-1:0];
    end
    if (|i_req) begin
      w_onehot[w_winner] = 1'b1;
    end
  end

  assign o_found  = |i_req;
  assign o_winner = w_winner;
  assign o_onehot = w_onehot;

endmodule
`default_nettype wire

// File: rtl/rr_arbiter_n.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter_n
// Description : N-requester round-robin arbiter with registered one-hot grant
//               and optional capped grant lock.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter_n
  import arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int LOCK_EN  = 1,
  parameter int MAX_HOLD = 8,
  parameter int ID_W     = clog2_min1(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] lock,
  output logic [NUM_REQ-1:0] grant,
  output logic               grant_valid,
  output logic [ID_W-1:0]    grant_id,
  output logic               locked
);

  localparam int              HC_W       = $clog2(MAX_HOLD + 1);
  localparam logic [HC_W-1:0] C_MAX_HOLD = HC_W'(MAX_HOLD);
  localparam logic [ID_W-1:0] C_LAST     = ID_W'(NUM_REQ - 1);

  arb_state_e         r_state,       w_state;
  logic [NUM_REQ-1:0] r_grant,       w_grant;
  logic               r_grant_valid, w_grant_valid;
  logic [ID_W-1:0]    r_grant_id,    w_grant_id;
  logic [ID_W-1:0]    r_ptr,         w_ptr;
  logic [HC_W-1:0]    r_hold_cnt,    w_hold_cnt;
  logic               r_locked,      w_locked;

  logic               w_found;
  logic [ID_W-1:0]    w_winner;
  logic [NUM_REQ-1:0] w_onehot;
  logic               w_cont;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .i_req    (req),
    .i_ptr    (r_ptr),
    .o_found  (w_found),
    .o_winner (w_winner),
    .o_onehot (w_onehot)
  );

  assign w_cont = (LOCK_EN != 0) && (r_state != IDLE) &&
                  req[r_grant_id] && lock[r_grant_id] &&
                  (r_hold_cnt < C_MAX_HOLD);

  always_comb begin
    w_state    = r_state;
    w_grant    = r_grant;
    w_grant_id = r_grant_id;
    w_ptr      = r_ptr;
    w_hold_cnt = r_hold_cnt;
    w_locked   = 1'b0;
    if (w_cont) begin
      // Pointer already sits one past the holder, so it stays put.
      w_state    = LOCKED;
      w_hold_cnt = r_hold_cnt + HC_W'(1);
      w_locked   = 1'b1;
    end else if (w_found) begin
      w_state    = GRANT;
      w_grant    = w_onehot;
      w_grant_id = w_winner;
      w_ptr      = (w_winner == C_LAST) ? '0 : w_winner + ID_W'(1);
      w_hold_cnt = HC_W'(1);
    end else begin
      w_state    = IDLE;
      w_grant    = '0;
      w_grant_id = '0;
      w_hold_cnt = '0;
    end
    w_grant_valid = |w_grant;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_grant       <= '0;
      r_grant_valid <= 1'b0;
      r_grant_id    <= '0;
      r_ptr         <= '0;
      r_hold_cnt    <= '0;
      r_locked      <= 1'b0;
    end else begin
      r_state       <= w_state;
      r_grant       <= w_grant;
      r_grant_valid <= w_grant_valid;
      r_grant_id    <= w_grant_id;
      r_ptr         <= w_ptr;
      r_hold_cnt    <= w_hold_cnt;
      r_locked      <= w_locked;
    end
  end

`ifdef ARB_DEBUG
  always @(posedge clk) begin
    if (reset_n && r_grant_valid) begin
      $display("[%0t] arb grant_id=%0d locked=%0b hold=%0d", $time, r_grant_id, r_locked, r_hold_cnt);
    end
  end
`endif

  assign grant       = r_grant;
  assign grant_valid = r_grant_valid;
  assign grant_id    = r_grant_id;
  assign locked      = r_locked;

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter_n.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_arbiter_n
// Description : Scoreboard bench for rr_arbiter_n (4-port locking and
//               2-port non-locking instances).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_arbiter_n;

  typedef struct {
    int         due;
    int         dut;
    logic [3:0] g;
    logic [1:0] id;
    logic       lk;
    string      nm;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] req4 = '0, lock4 = '0;
  logic [1:0] req2 = '0, lock2 = '0;
  logic [3:0] g4;
  logic       gv4, lk4;
  logic [1:0] id4;
  logic [1:0] g2;
  logic       gv2, lk2;
  logic [0:0] id2;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rr_arbiter_n #(.NUM_REQ(4), .LOCK_EN(1), .MAX_HOLD(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .req(req4), .lock(lock4),
    .grant(g4), .grant_valid(gv4), .grant_id(id4), .locked(lk4)
  );

  rr_arbiter_n #(.NUM_REQ(2), .LOCK_EN(0), .MAX_HOLD(8)) dut2 (
    .clk(clk), .reset_n(reset_n), .req(req2), .lock(lock2),
    .grant(g2), .grant_valid(gv2), .grant_id(id2), .locked(lk2)
  );

  always @(posedge clk) begin
    if (reset_n) begin
      assert (!$isunknown({req4, lock4, req2, lock2}))
        else $error("req/lock unknown after reset");
    end
  end

  function automatic logic [1:0] idx(input logic [3:0] g);
    logic [1:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) if (g[i]) r = 2'(i);
    return r;
  endfunction

  // Monitor: compares every due scoreboard entry against the selected DUT.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      exp_t       e;
      logic [3:0] ag;
      logic [1:0] aid;
      logic       av, al;
      e = sb.pop_front();
      if (e.dut == 4) begin
        ag = g4; aid = id4; av = gv4; al = lk4;
      end else begin
        ag = {2'b00, g2}; aid = {1'b0, id2}; av = gv2; al = lk2;
      end
      checks++;
      if (ag !== e.g || aid !== e.id || av !== (|e.g) || al !== e.lk) begin
        failures++;
        $display("FAIL %s cyc=%0d: got grant=%b id=%0d valid=%b locked=%b, want grant=%b id=%0d valid=%b locked=%b",
                 e.nm, cyc, ag, aid, av, al, e.g, e.id, |e.g, e.lk);
      end
    end
  end

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic step4(input logic [3:0] r, input logic [3:0] l,
                       input logic [3:0] eg, input logic el, input string nm);
    exp_t e;
    @(posedge clk); #1;
    req4 = r; lock4 = l;
    e.due = cyc + 1; e.dut = 4; e.g = eg; e.id = idx(eg); e.lk = el; e.nm = nm;
    sb.push_back(e);
  endtask

  task automatic step2(input logic [1:0] r, input logic [1:0] l,
                       input logic [1:0] eg, input string nm);
    exp_t e;
    @(posedge clk); #1;
    req2 = r; lock2 = l;
    e.due = cyc + 1; e.dut = 2; e.g = {2'b00, eg}; e.id = idx({2'b00, eg}); e.lk = 1'b0; e.nm = nm;
    sb.push_back(e);
  endtask

  initial begin
    req4 = 4'bxxxx;
    repeat (3) @(posedge clk);
    #2;
    req4 = '0;
    chk("reset_state4", {g4, id4, gv4, lk4}, 8'h00);
    chk("reset_state2", {4'b0, g2, id2, gv2}, 8'h00);
    reset_n = 1'b1;

    // Full contention rotation from ptr=0
    for (int i = 0; i < 8; i++) step4(4'b1111, 4'b0000, 4'b0001 << (i % 4), 1'b0, "rotate");

    // Wrap and skip: grant 0100 leaves ptr=3
    step4(4'b0100, 4'b0000, 4'b0100, 1'b0, "wrap_setup");
    step4(4'b0011, 4'b0000, 4'b0001, 1'b0, "wrap_first");
    step4(4'b0011, 4'b0000, 4'b0010, 1'b0, "wrap_second");
    step4(4'b0000, 4'b0000, 4'b0000, 1'b0, "idle");
    step4(4'b0001, 4'b0000, 4'b0001, 1'b0, "idle_wrap");
    step4(4'b1000, 4'b0000, 4'b1000, 1'b0, "ptr_to_0");

    // Lock cap with MAX_HOLD=4, then handover without a bubble
    step4(4'b1001, 4'b0001, 4'b0001, 1'b0, "cap_c1");
    step4(4'b1001, 4'b0001, 4'b0001, 1'b1, "cap_c2");
    step4(4'b1001, 4'b0001, 4'b0001, 1'b1, "cap_c3");
    step4(4'b1001, 4'b0001, 4'b0001, 1'b1, "cap_c4");
    step4(4'b1001, 4'b0001, 4'b1000, 1'b0, "cap_handover");
    step4(4'b1001, 4'b0001, 4'b0001, 1'b0, "lock_nonholder_ignored");

    // Early release of a lock
    step4(4'b0100, 4'b0100, 4'b0100, 1'b0, "early_g");
    step4(4'b0110, 4'b0100, 4'b0100, 1'b1, "early_lock");
    step4(4'b0010, 4'b0100, 4'b0010, 1'b0, "early_release");
    step4(4'b0000, 4'b0000, 4'b0000, 1'b0, "early_idle");

    // Sole requester hits the cap and is re-granted unlocked
    step4(4'b0001, 4'b0001, 4'b0001, 1'b0, "sole_c1");
    for (int i = 0; i < 3; i++) step4(4'b0001, 4'b0001, 4'b0001, 1'b1, "sole_lock");
    step4(4'b0001, 4'b0001, 4'b0001, 1'b0, "sole_regrant");
    step4(4'b0001, 4'b0001, 4'b0001, 1'b1, "sole_relock");
    step4(4'b0000, 4'b0000, 4'b0000, 1'b0, "sole_idle");

    // Asynchronous reset in the middle of a locked burst
    step4(4'b0100, 4'b0100, 4'b0100, 1'b0, "burst_g");
    step4(4'b0100, 4'b0100, 4'b0100, 1'b1, "burst_lock");
    @(posedge clk);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    req4 = '0; lock4 = '0;
    #1;
    chk("async_reset_grant", {4'b0, g4}, 8'h00);
    chk("async_reset_flags", {4'b0, id4, gv4, lk4}, 8'h00);
    @(posedge clk); #1;
    reset_n = 1'b1;
    step4(4'b0000, 4'b0000, 4'b0000, 1'b0, "post_reset_idle1");
    step4(4'b0000, 4'b0000, 4'b0000, 1'b0, "post_reset_idle2");
    step4(4'b1111, 4'b0000, 4'b0001, 1'b0, "post_reset_ptr0");
    step4(4'b1111, 4'b0000, 4'b0010, 1'b0, "post_reset_next");
    step4(4'b0000, 4'b0000, 4'b0000, 1'b0, "post_reset_drop");

    // LOCK_EN=0, NUM_REQ=2: strict alternation, lock ignored
    step2(2'b11, 2'b11, 2'b01, "nolock_a0");
    step2(2'b11, 2'b11, 2'b10, "nolock_a1");
    step2(2'b11, 2'b11, 2'b01, "nolock_a2");
    step2(2'b11, 2'b11, 2'b10, "nolock_a3");
    step2(2'b00, 2'b00, 2'b00, "nolock_idle");

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending entries, want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rr_arbiter_n.md
Name: rr_arbiter_n

Overview:
- Parametrised N-requester round-robin arbiter. Next generation of the team's 2-port toggle arbiter.
- Grants are registered and one-hot, with a rotating priority pointer.
- Optional grant lock lets a requester hold the resource for bursts, with a hold-time cap for fairness.
- Sits between pipeline masters and a single shared resource (memory port or bus) in the global-stall pipeline.

Parameters:
- NUM_REQ, 4: number of requesters; legal range 2..16.
- LOCK_EN, 1: 1 = honour lock inputs; 0 = lock ignored, every grant lasts one cycle.
- MAX_HOLD, 8: maximum consecutive cycles one requester may hold a locked grant; legal range ≥1.
- ID_W, $clog2(NUM_REQ): width of grant_id; derived, do not override.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-requester request, level-sensitive.
- lock  in  NUM_REQ  per-requester "keep grant" qualifier; only meaningful while granted.
- grant  out  NUM_REQ  registered one-hot grant; all zero when idle.
- grant_valid  out  1  OR-reduction of grant, registered.
- grant_id  out  ID_W  binary index of the granted requester; 0 when idle.
- locked  out  1  high while the current grant continues a lock from the previous cycle.

Behaviour:
- Reset (reset_n low, async):
  - grant = 0, grant_valid = 0, grant_id = 0, locked = 0.
  - Pointer ptr = 0, hold_cnt = 0, state = IDLE.
  - Reset mid-burst drops the grant immediately, with no wait for the clock edge.
- Latency: req sampled at edge t produces grant visible after edge t. Fixed one-cycle latency, no combinational req->grant path.
- State machine:
  - IDLE: no grant.
  - GRANT: single-cycle grant.
  - LOCKED: grant held from the previous cycle.
- Arbitration at each edge, when not continuing a lock:
  - Search req starting at index ptr, ascending, wrapping modulo NUM_REQ. The first set bit i wins.
  - Next state GRANT, grant = one-hot(i), ptr <= (i+1) mod NUM_REQ, hold_cnt <= 1.
  - If req == 0: next state IDLE, grant = 0, ptr unchanged.
- Lock continuation:
  - Condition: LOCK_EN=1, current holder h has req[h]=1 and lock[h]=1, and hold_cnt < MAX_HOLD.
  - Result: grant stays h, state LOCKED, hold_cnt <= hold_cnt+1, ptr unchanged (already h+1), locked = 1.
- Lock end:
  - Holder drops req or lock, or hold_cnt reaches MAX_HOLD: re-arbitrate on the same edge. No idle bubble.
  - ptr = h+1 gives h lowest priority, so any other requester wins before h is re-granted.
  - If h is the only requester, it is re-granted: state GRANT, hold_cnt = 1, locked = 0.
- MAX_HOLD=1 is equivalent to LOCK_EN=0.
- lock[j] for a non-granted j is ignored.
- hold_cnt width is $clog2(MAX_HOLD+1). It saturates and never wraps.
- NUM_REQ=2 with all requesters permanently requesting gives strict alternation 0,1,0,1…
- X on req during reset is a don't-care. After reset deassert, req is assumed clean (assertion in bench).
- Invariants: grant is always one-hot or zero; grant_id is consistent with grant; grant_valid = |grant.

Decomposition:
- Package arb_pkg:
  - ID width function clog2_min1 (returns ≥1).
  - State enum {IDLE, GRANT, LOCKED}.
  - Constant ARB_MAX_REQ = 16.
- Sub-module rr_pick: combinational rotate-priority picker.
  - Inputs: req vector, ptr.
  - Outputs: found, winner index, one-hot.
  - Implemented as a double-width rotate plus priority encoder.
- rr_arbiter_n holds the registers and FSM only.
- Debug $display lines sit under `ifdef ARB_DEBUG`.

Test Plan:
- Reset while granted: NUM_REQ=4, grant=0100 locked; assert reset_n low between edges -> grant, grant_id, grant_valid and locked go to 0 immediately. After release with req=0000 -> stays idle.
- Full contention rotation: req=1111, lock=0, 8 cycles -> grant sequence 0001,0010,0100,1000,0001,… with grant_id 0,1,2,3,0.
- Wrap and skip: ptr=3 (after grant 0100), req=0011 -> grant 0001, then 0010.
- Lock cap: MAX_HOLD=4, req=1001, lock[0]=1 -> grant 0001 for 4 cycles with locked=0,1,1,1, then grant 1000 on the 5th cycle without a bubble.
- Early release: holder 2 locked, req[2] dropped at cycle 2 while req[1]=1 -> next cycle grant 0010, no idle cycle.
- LOCK_EN=0 regression: req=11 on NUM_REQ=2 with lock=11 -> alternation 01,10,01; lock ignored; locked stays 0.
